// File: rtl/jtag_tap_pkg.sv
// Shared TAP definitions: IEEE state encoding, BYPASS opcode and the IR capture pattern.
package jtag_tap_pkg;

    typedef enum logic [3:0] {
        EX2_DR   = 4'h0,
        EX1_DR   = 4'h1,
        SH_DR    = 4'h2,
        PAUSE_DR = 4'h3,
        SEL_IR   = 4'h4,
        UPD_DR   = 4'h5,
        CAP_DR   = 4'h6,
        SEL_DR   = 4'h7,
        EX2_IR   = 4'h8,
        EX1_IR   = 4'h9,
        SH_IR    = 4'hA,
        PAUSE_IR = 4'hB,
        RTI      = 4'hC,
        UPD_IR   = 4'hD,
        CAP_IR   = 4'hE,
        TLR      = 4'hF
    } tap_state_e;

    localparam int                      MAX_IR_WIDTH = 32;
    localparam logic [MAX_IR_WIDTH-1:0] BYPASS_OP    = '1;
    localparam logic [1:0]              CAPTURE_PAT  = 2'b01;

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP state machine: state register plus TMS-driven next-state logic.
module jtag_tap_fsm
    import jtag_tap_pkg::*;
(
    input  logic       TCK,
    input  logic       reset,
    input  logic       TMS,
    output logic [3:0] State
);

    tap_state_e state_q, state_d;

    always_ff @(posedge TCK) begin
        if (reset) state_q <= TLR;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            TLR:      state_d = TMS ? TLR    : RTI;
            RTI:      state_d = TMS ? SEL_DR : RTI;
            SEL_DR:   state_d = TMS ? SEL_IR : CAP_DR;
            CAP_DR:   state_d = TMS ? EX1_DR : SH_DR;
            SH_DR:    state_d = TMS ? EX1_DR : SH_DR;
            EX1_DR:   state_d = TMS ? UPD_DR : PAUSE_DR;
            PAUSE_DR: state_d = TMS ? EX2_DR : PAUSE_DR;
            EX2_DR:   state_d = TMS ? UPD_DR : SH_DR;
            UPD_DR:   state_d = TMS ? SEL_DR : RTI;
            SEL_IR:   state_d = TMS ? TLR    : CAP_IR;
            CAP_IR:   state_d = TMS ? EX1_IR : SH_IR;
            SH_IR:    state_d = TMS ? EX1_IR : SH_IR;
            EX1_IR:   state_d = TMS ? UPD_IR : PAUSE_IR;
            PAUSE_IR: state_d = TMS ? EX2_IR : PAUSE_IR;
            EX2_IR:   state_d = TMS ? UPD_IR : SH_IR;
            UPD_IR:   state_d = TMS ? SEL_DR : RTI;
        endcase
    end

    assign State = state_q;

endmodule

// File: rtl/jtag_tap_controller.sv
// TAP controller: FSM, enable decode, instruction register and DR-select decode.
// Optional macro JTAG_TAP_IDCODE_EN: IDCODE support and IDCODE as reset instruction (else BYPASS).
module jtag_tap_controller
    import jtag_tap_pkg::*;
#(
    parameter int                  IR_WIDTH  = 4,
    parameter logic [IR_WIDTH-1:0] OP_EXTEST = IR_WIDTH'(4'b0000),
    parameter logic [IR_WIDTH-1:0] OP_SAMPLE = IR_WIDTH'(4'b0010),
    parameter logic [IR_WIDTH-1:0] OP_IDCODE = IR_WIDTH'(4'b0001)
) (
    input  logic                TCK,
    input  logic                reset,
    input  logic                TMS,
    input  logic                TDI,
    output logic [3:0]          State,
    output logic                CaptureDR,
    output logic                ShiftDR,
    output logic                UpdateDR,
    output logic                CaptureIR,
    output logic                ShiftIR,
    output logic                UpdateIR,
    output logic                Select,
    output logic                Enable,
    output logic                IrTdo,
    output logic [IR_WIDTH-1:0] IrOut,
    output logic                SelBypass,
    output logic                SelIdcode,
    output logic                SelBoundary
);

    localparam logic [IR_WIDTH-1:0] BYPASS  = BYPASS_OP[IR_WIDTH-1:0];
    localparam logic [IR_WIDTH-1:0] CAPTURE = IR_WIDTH'(CAPTURE_PAT);
`ifdef JTAG_TAP_IDCODE_EN
    localparam logic [IR_WIDTH-1:0] RESET_INSTR = OP_IDCODE;
`else
    localparam logic [IR_WIDTH-1:0] RESET_INSTR = BYPASS;
`endif

    logic [3:0]          state_w;
    logic [IR_WIDTH-1:0] ir_shift_q, ir_shift_d;
    logic [IR_WIDTH-1:0] ir_out_q, ir_out_d;

    jtag_tap_fsm u_fsm (
        .TCK   (TCK),
        .reset (reset),
        .TMS   (TMS),
        .State (state_w)
    );

    always_comb begin
        CaptureDR = (state_w == CAP_DR);
        ShiftDR   = (state_w == SH_DR);
        UpdateDR  = (state_w == UPD_DR);
        CaptureIR = (state_w == CAP_IR);
        ShiftIR   = (state_w == SH_IR);
        UpdateIR  = (state_w == UPD_IR);
        Enable    = ShiftDR | ShiftIR;
        // Select-IR itself still routes the DR path; only the IR column after it selects IR.
        Select    = state_w inside {CAP_IR, SH_IR, EX1_IR, PAUSE_IR, EX2_IR, UPD_IR};
    end

    always_comb begin
        ir_shift_d = ir_shift_q;
        ir_out_d   = ir_out_q;
        if (state_w == CAP_IR)     ir_shift_d = CAPTURE;
        else if (state_w == SH_IR) ir_shift_d = {TDI, ir_shift_q[IR_WIDTH-1:1]};
        if (state_w == UPD_IR)     ir_out_d = ir_shift_q;
        else if (state_w == TLR)   ir_out_d = RESET_INSTR;
    end

    always_ff @(posedge TCK) begin
        if (reset) begin
            ir_shift_q <= CAPTURE;
            ir_out_q   <= RESET_INSTR;
        end else begin
            ir_shift_q <= ir_shift_d;
            ir_out_q   <= ir_out_d;
        end
    end

    always_comb begin
        SelBypass   = 1'b0;
        SelIdcode   = 1'b0;
        SelBoundary = 1'b0;
`ifdef JTAG_TAP_IDCODE_EN
        if (ir_out_q == OP_IDCODE)                                 SelIdcode   = 1'b1;
        else if (ir_out_q == OP_EXTEST || ir_out_q == OP_SAMPLE)   SelBoundary = 1'b1;
        else                                                       SelBypass   = 1'b1;
`else
        if (ir_out_q == OP_EXTEST || ir_out_q == OP_SAMPLE)        SelBoundary = 1'b1;
        else                                                       SelBypass   = 1'b1;
`endif
    end

    assign State = state_w;
    assign IrTdo = ir_shift_q[0];
    assign IrOut = ir_out_q;

endmodule

// File: tb/tb_jtag_tap_controller.sv
// Self-checking bench for jtag_tap_controller: vector table, hand sequences and a random walk vs a reference model.
module tb_jtag_tap_controller;

    localparam int W = 4;
`ifdef JTAG_TAP_IDCODE_EN
    localparam int RST = 1;
`else
    localparam int RST = 15;
`endif

    logic         TCK = 1'b0;
    logic         reset, TMS, TDI;
    logic [3:0]   State;
    logic         CaptureDR, ShiftDR, UpdateDR, CaptureIR, ShiftIR, UpdateIR;
    logic         Select, Enable, IrTdo;
    logic [W-1:0] IrOut;
    logic         SelBypass, SelIdcode, SelBoundary;

    int checks   = 0;
    int failures = 0;

    // reference model state
    int           m_st;
    logic [W-1:0] m_sh, m_ir;
    int           nxt0[16];
    int           nxt1[16];

    typedef struct {
        logic rst;
        logic tms;
        logic tdi;
        int   st;
        int   sel;
        int   en;
        int   tdo;
        int   ir;
    } vec_t;
    vec_t tbl[25];

    jtag_tap_controller dut (
        .TCK(TCK), .reset(reset), .TMS(TMS), .TDI(TDI), .State(State),
        .CaptureDR(CaptureDR), .ShiftDR(ShiftDR), .UpdateDR(UpdateDR),
        .CaptureIR(CaptureIR), .ShiftIR(ShiftIR), .UpdateIR(UpdateIR),
        .Select(Select), .Enable(Enable), .IrTdo(IrTdo), .IrOut(IrOut),
        .SelBypass(SelBypass), .SelIdcode(SelIdcode), .SelBoundary(SelBoundary)
    );

    always #5 TCK = ~TCK;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // {bypass, idcode, boundary}
    function automatic int dec(input logic [W-1:0] ir);
`ifdef JTAG_TAP_IDCODE_EN
        if (ir == 4'b0001) return 2;
`endif
        if (ir == 4'b0000 || ir == 4'b0010) return 1;
        return 4;
    endfunction

    function automatic int in_ir_column(input int s);
        return (s == 14 || s == 10 || s == 9 || s == 11 || s == 8 || s == 13) ? 1 : 0;
    endfunction

    task automatic model_step(input logic r, input logic t, input logic d);
        logic [W-1:0] sh_n, ir_n;
        if (r) begin
            m_st = 15;
            m_sh = 4'b0001;
            m_ir = W'(RST);
        end else begin
            sh_n = m_sh;
            ir_n = m_ir;
            if (m_st == 14)      sh_n = 4'b0001;
            else if (m_st == 10) sh_n = (m_sh >> 1) | (W'(d) << (W - 1));
            if (m_st == 13)      ir_n = m_sh;
            else if (m_st == 15) ir_n = W'(RST);
            m_st = t ? nxt1[m_st] : nxt0[m_st];
            m_sh = sh_n;
            m_ir = ir_n;
        end
    endtask

    task automatic compare_model();
        int exp_ctl;
        exp_ctl = ((m_st == 6) << 7) | ((m_st == 2) << 6) | ((m_st == 5) << 5) |
                  ((m_st == 14) << 4) | ((m_st == 10) << 3) | ((m_st == 13) << 2) |
                  (in_ir_column(m_st) << 1) | ((m_st == 2 || m_st == 10) ? 1 : 0);
        chk("model_state", int'(State), m_st);
        chk("model_ctl", int'({CaptureDR, ShiftDR, UpdateDR, CaptureIR, ShiftIR, UpdateIR, Select, Enable}), exp_ctl);
        chk("model_irtdo", int'(IrTdo), int'(m_sh[0]));
        chk("model_irout", int'(IrOut), int'(m_ir));
        chk("model_decode", int'({SelBypass, SelIdcode, SelBoundary}), dec(m_ir));
    endtask

    task automatic cycle(input logic r, input logic t, input logic d);
        reset = r;
        TMS   = t;
        TDI   = d;
        @(posedge TCK);
        model_step(r, t, d);
        @(negedge TCK);
        compare_model();
    endtask

    task automatic load_ir(input logic [W-1:0] v);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < W; i++) cycle(1'b0, (i == W - 1), v[i]);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        chk($sformatf("load_ir_%0h", v), int'(IrOut), int'(v));
    endtask

    initial begin
        nxt0[15] = 12; nxt1[15] = 15;
        nxt0[12] = 12; nxt1[12] = 7;
        nxt0[7]  = 6;  nxt1[7]  = 4;
        nxt0[4]  = 14; nxt1[4]  = 15;
        nxt0[6]  = 2;  nxt1[6]  = 1;
        nxt0[2]  = 2;  nxt1[2]  = 1;
        nxt0[1]  = 3;  nxt1[1]  = 5;
        nxt0[3]  = 3;  nxt1[3]  = 0;
        nxt0[0]  = 2;  nxt1[0]  = 5;
        nxt0[5]  = 12; nxt1[5]  = 7;
        nxt0[14] = 10; nxt1[14] = 9;
        nxt0[10] = 10; nxt1[10] = 9;
        nxt0[9]  = 11; nxt1[9]  = 13;
        nxt0[11] = 11; nxt1[11] = 8;
        nxt0[8]  = 10; nxt1[8]  = 13;
        nxt0[13] = 12; nxt1[13] = 7;

        //            rst   tms   tdi   st  sel en  tdo  ir
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 15, 0, 0,  1, RST};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 12, 0, 0,  1, RST};
        tbl[2]  = '{1'b0, 1'b1, 1'b0,  7, 0, 0, -1, RST};
        tbl[3]  = '{1'b0, 1'b1, 1'b0,  4, 0, 0, -1, -1};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 14, 1, 0,  1, -1};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 10, 1, 1,  1, -1};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 10, 1, 1,  0, -1};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 10, 1, 1,  0, -1};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 10, 1, 1,  0, -1};
        tbl[9]  = '{1'b0, 1'b1, 1'b0,  9, 1, 0,  0, RST};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 13, 1, 0,  0, RST};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 12, 0, 0,  0, 2};
        tbl[12] = '{1'b0, 1'b1, 1'b0,  7, 0, 0,  0, 2};
        tbl[13] = '{1'b0, 1'b1, 1'b0,  4, 0, 0,  0, 2};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 14, 1, 0,  0, 2};
        tbl[15] = '{1'b0, 1'b0, 1'b1, 10, 1, 1,  1, 2};
        tbl[16] = '{1'b0, 1'b1, 1'b1,  9, 1, 0,  0, 2};
        tbl[17] = '{1'b0, 1'b0, 1'b1, 11, 1, 0,  0, 2};
        tbl[18] = '{1'b0, 1'b0, 1'b1, 11, 1, 0,  0, 2};
        tbl[19] = '{1'b0, 1'b1, 1'b1,  8, 1, 0,  0, 2};
        tbl[20] = '{1'b0, 1'b0, 1'b1, 10, 1, 1,  0, 2};
        tbl[21] = '{1'b0, 1'b0, 1'b1, 10, 1, 1,  0, 2};
        tbl[22] = '{1'b0, 1'b1, 1'b1,  9, 1, 0,  0, 2};
        tbl[23] = '{1'b0, 1'b1, 1'b0, 13, 1, 0,  0, 2};
        tbl[24] = '{1'b0, 1'b0, 1'b0, 12, 0, 0,  0, 14};

        reset = 1'b1;
        TMS   = 1'b0;
        TDI   = 1'b0;
        @(negedge TCK);

        for (int i = 0; i < 25; i++) begin
            cycle(tbl[i].rst, tbl[i].tms, tbl[i].tdi);
            chk($sformatf("tbl%0d_state", i), int'(State), tbl[i].st);
            chk($sformatf("tbl%0d_select", i), int'(Select), tbl[i].sel);
            chk($sformatf("tbl%0d_enable", i), int'(Enable), tbl[i].en);
            if (tbl[i].tdo >= 0) chk($sformatf("tbl%0d_irtdo", i), int'(IrTdo), tbl[i].tdo);
            if (tbl[i].ir >= 0) begin
                chk($sformatf("tbl%0d_irout", i), int'(IrOut), tbl[i].ir);
                chk($sformatf("tbl%0d_decode", i), int'({SelBypass, SelIdcode, SelBoundary}),
                    dec(W'(tbl[i].ir)));
            end
        end

        // Five TMS=1 cycles escape from Shift-DR; the reset instruction lands one cycle later.
        load_ir(4'b1111);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        chk("esc_in_shdr", int'(State), 2);
        chk("esc_shiftdr", int'(ShiftDR), 1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0);
        chk("esc_tlr", int'(State), 15);
        chk("esc_irout_held", int'(IrOut), 15);
        cycle(1'b0, 1'b1, 1'b0);
        chk("esc_irout_rst", int'(IrOut), RST);

        load_ir(4'b0111);
        chk("undef_bypass", int'({SelBypass, SelIdcode, SelBoundary}), 4);
        load_ir(4'b0000);
        chk("extest_boundary", int'(SelBoundary), 1);
        load_ir(4'b0001);
`ifdef JTAG_TAP_IDCODE_EN
        chk("idcode_sel", int'(SelIdcode), 1);
`else
        chk("idcode_sel", int'(SelIdcode), 0);
`endif

        // Reset in the middle of an IR shift.
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1);
        chk("mid_in_shir", int'(State), 10);
        cycle(1'b1, 1'b0, 1'b1);
        chk("mid_rst_state", int'(State), 15);
        chk("mid_rst_shift", int'(dut.ir_shift_q), 1);
        chk("mid_rst_irout", int'(IrOut), RST);
        chk("mid_rst_select", int'(Select), 0);

        for (int i = 0; i < 3000; i++)
            cycle(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
